// File: rtl/window5_pkg.sv
// Shared definitions for the 5x5 window sequencer: window geometry, FSM states
// and the centre-delay helper.
// Latency: n/a (definitions only).  Backpressure: n/a.
package window5_pkg;

  localparam int unsigned WIN_SIZE   = 5;
  localparam int unsigned WIN_RADIUS = (WIN_SIZE - 1) / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Number of shifts between a pixel entering the buffer and that pixel
  // reaching the grid centre (row 2, col 2).
  function automatic int unsigned calc_delay(input int unsigned line_width);
    return WIN_RADIUS * line_width + WIN_RADIUS;
  endfunction

endpackage

// File: rtl/window5_sequencer_frame_pos_counter.sv
// Raster x/y position counter: x wraps to 0 at P_WIDTH-1 and bumps y.
// Latency: position updates on the clock edge after i_en; o_last is combinational.
// Backpressure: none; holds while i_en is low and stops once (P_WIDTH-1, P_HEIGHT-1) is reached.
// Ports: i_clk, i_reset (sync, active-high), i_clr (sync clear), i_en (advance),
//        o_x / o_y (current position), o_last (position is the final one of the frame).
module frame_pos_counter #(
  parameter int unsigned P_WIDTH  = 640,
  parameter int unsigned P_HEIGHT = 480,
  localparam int unsigned LP_XW = $clog2(P_WIDTH),
  localparam int unsigned LP_YW = $clog2(P_HEIGHT)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [LP_XW-1:0] o_x,
  output logic [LP_YW-1:0] o_y,
  output logic             o_last
);

  localparam logic [LP_XW-1:0] LP_X_MAX = LP_XW'(P_WIDTH - 1);
  localparam logic [LP_YW-1:0] LP_Y_MAX = LP_YW'(P_HEIGHT - 1);

  logic [LP_XW-1:0] r_x;
  logic [LP_YW-1:0] r_y;
  logic             w_last;

  assign w_last = (r_x == LP_X_MAX) && (r_y == LP_Y_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en && !w_last) begin
      if (r_x == LP_X_MAX) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_last;

endmodule

// File: rtl/window5_sequencer.sv
// Sequencer for the 5-line window buffer: feeds/enables/clears the buffer and
// reports the frame coordinate, border flag and pixel of the current window centre.
// Latency: buf_* outputs combinational; center_* registered on the shift edge (valid the next cycle).
// Backpressure: none; pixel_valid gaps stall all counters, frame tail is flushed internally.
// Ports: i_clk, i_reset (sync, active-high), i_frame_start, i_pixel_valid, i_pixel_in,
//        i_grid_center_in (buffer grid centre) ; o_buf_shiftin, o_buf_clken, o_buf_ram_clr,
//        o_center_valid/x/y/border/pixel, o_frame_done.
// Build option: WINDOW5_BORDER_ZERO_EN forces o_center_pixel to 0 on border centres.
module window5_sequencer
  import window5_pkg::*;
#(
  parameter int unsigned P_BIT_WIDTH    = 24,
  parameter int unsigned P_LINE_WIDTH   = 640,
  parameter int unsigned P_FRAME_HEIGHT = 480
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_frame_start,
  input  logic                              i_pixel_valid,
  input  logic [P_BIT_WIDTH-1:0]            i_pixel_in,
  input  logic [P_BIT_WIDTH-1:0]            i_grid_center_in,
  output logic [P_BIT_WIDTH-1:0]            o_buf_shiftin,
  output logic                              o_buf_clken,
  output logic                              o_buf_ram_clr,
  output logic                              o_center_valid,
  output logic [$clog2(P_LINE_WIDTH)-1:0]   o_center_x,
  output logic [$clog2(P_FRAME_HEIGHT)-1:0] o_center_y,
  output logic                              o_center_border,
  output logic [P_BIT_WIDTH-1:0]            o_center_pixel,
  output logic                              o_frame_done
);

  localparam int unsigned LP_XW = $clog2(P_LINE_WIDTH);
  localparam int unsigned LP_YW = $clog2(P_FRAME_HEIGHT);
  localparam int unsigned LP_D  = calc_delay(P_LINE_WIDTH);

  // Shift index D expressed as a raster position, so "n >= D" becomes a
  // position compare on the input counter instead of a separate fill counter.
  localparam logic [LP_XW-1:0] LP_D_X  = LP_XW'(LP_D % P_LINE_WIDTH);
  localparam logic [LP_YW-1:0] LP_D_Y  = LP_YW'(LP_D / P_LINE_WIDTH);
  localparam logic [LP_XW-1:0] LP_R_X  = LP_XW'(WIN_RADIUS);
  localparam logic [LP_YW-1:0] LP_R_Y  = LP_YW'(WIN_RADIUS);
  localparam logic [LP_XW-1:0] LP_X_HI = LP_XW'(P_LINE_WIDTH - WIN_RADIUS);
  localparam logic [LP_YW-1:0] LP_Y_HI = LP_YW'(P_FRAME_HEIGHT - WIN_RADIUS);

  state_t r_state, w_state_nxt;

  logic [LP_XW-1:0] w_in_x, w_ctr_x;
  logic [LP_YW-1:0] w_in_y, w_ctr_y;
  logic             w_in_last, w_ctr_last;
  logic             w_clr, w_abort, w_adv, w_has_ctr, w_emit, w_done, w_border;

  logic             r_center_valid;
  logic [LP_XW-1:0] r_center_x;
  logic [LP_YW-1:0] r_center_y;
  logic             r_center_border;
  logic             r_frame_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_done        = 1'b0;
    o_buf_clken   = 1'b0;
    o_buf_shiftin = '0;
    o_buf_ram_clr = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_frame_start) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        o_buf_ram_clr = 1'b1;
        w_state_nxt   = RUN;
      end
      RUN: begin
        o_buf_clken   = i_pixel_valid;
        o_buf_shiftin = i_pixel_in;
        if (i_frame_start)                  w_state_nxt = CLEAR;
        else if (i_pixel_valid && w_in_last) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        o_buf_clken = 1'b1;
        // The final flush shift is the one that emits the frame's last centre.
        if (i_frame_start) begin
          w_state_nxt = CLEAR;
        end else if (w_ctr_last) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_clr     = (r_state == CLEAR);
  assign w_abort   = i_frame_start && ((r_state == RUN) || (r_state == FLUSH));
  assign w_adv     = o_buf_clken && !w_abort;
  // In FLUSH every shift is past N-1 >= D, so a centre always exists.
  assign w_has_ctr = (r_state == FLUSH) || (w_in_y > LP_D_Y) ||
                     ((w_in_y == LP_D_Y) && (w_in_x >= LP_D_X));
  assign w_emit    = w_adv && w_has_ctr;
  assign w_border  = (w_ctr_x < LP_R_X) || (w_ctr_x >= LP_X_HI) ||
                     (w_ctr_y < LP_R_Y) || (w_ctr_y >= LP_Y_HI);

  frame_pos_counter #(
    .P_WIDTH  (P_LINE_WIDTH),
    .P_HEIGHT (P_FRAME_HEIGHT)
  ) u_in_pos (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_en    (w_adv && (r_state == RUN)),
    .o_x     (w_in_x),
    .o_y     (w_in_y),
    .o_last  (w_in_last)
  );

  frame_pos_counter #(
    .P_WIDTH  (P_LINE_WIDTH),
    .P_HEIGHT (P_FRAME_HEIGHT)
  ) u_ctr_pos (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_en    (w_emit),
    .o_x     (w_ctr_x),
    .o_y     (w_ctr_y),
    .o_last  (w_ctr_last)
  );

  // Registered on the same edge the buffer shifts, so these line up with
  // i_grid_center_in in the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_center_valid  <= 1'b0;
      r_center_x      <= '0;
      r_center_y      <= '0;
      r_center_border <= 1'b0;
      r_frame_done    <= 1'b0;
    end else begin
      r_center_valid  <= w_emit;
      r_center_border <= w_emit && w_border;
      r_frame_done    <= w_done;
      if (w_emit) begin
        r_center_x <= w_ctr_x;
        r_center_y <= w_ctr_y;
      end
    end
  end

  assign o_center_valid  = r_center_valid;
  assign o_center_x      = r_center_x;
  assign o_center_y      = r_center_y;
  assign o_center_border = r_center_border;
  assign o_frame_done    = r_frame_done;

`ifdef WINDOW5_BORDER_ZERO_EN
  assign o_center_pixel = (r_center_valid && !r_center_border) ? i_grid_center_in : '0;
`else
  assign o_center_pixel = r_center_valid ? i_grid_center_in : '0;
`endif

endmodule

// File: tb/tb_window5_sequencer.sv
// Testbench for window5_sequencer with an 8x6 frame and a behavioural window buffer.
// Expected centres come from frame indices: centre of shift n is pixel n-D at (k%W, k/W).
module tb_window5_sequencer;

  localparam int LW = 8;
  localparam int FH = 6;
  localparam int BW = 24;
  localparam int D  = 2 * LW + 2;
  localparam int N  = LW * FH;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          pixel_valid;
  logic [BW-1:0] pixel_in;
  logic [BW-1:0] grid_center_in;
  logic [BW-1:0] buf_shiftin;
  logic          buf_clken;
  logic          buf_ram_clr;
  logic          center_valid;
  logic [2:0]    center_x;
  logic [2:0]    center_y;
  logic          center_border;
  logic [BW-1:0] center_pixel;
  logic          frame_done;

  always #5 clk = ~clk;

  window5_sequencer #(
    .P_BIT_WIDTH    (BW),
    .P_LINE_WIDTH   (LW),
    .P_FRAME_HEIGHT (FH)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_frame_start    (frame_start),
    .i_pixel_valid    (pixel_valid),
    .i_pixel_in       (pixel_in),
    .i_grid_center_in (grid_center_in),
    .o_buf_shiftin    (buf_shiftin),
    .o_buf_clken      (buf_clken),
    .o_buf_ram_clr    (buf_ram_clr),
    .o_center_valid   (center_valid),
    .o_center_x       (center_x),
    .o_center_y       (center_y),
    .o_center_border  (center_border),
    .o_center_pixel   (center_pixel),
    .o_frame_done     (frame_done)
  );

  // Window buffer model: the grid centre holds the value shifted in D shifts ago.
  logic [BW-1:0] hist [0:D];
  always @(posedge clk) begin
    if (buf_ram_clr) begin
      for (int i = 0; i <= D; i++) hist[i] <= '0;
    end else if (buf_clken) begin
      hist[0] <= buf_shiftin;
      for (int i = 1; i <= D; i++) hist[i] <= hist[i-1];
    end
  end
  assign grid_center_in = hist[D];

  int total = 0;
  int bad   = 0;
  int n_centres = 0;
  int n_done    = 0;
  logic [BW-1:0] pix [0:N-1];

  always @(negedge clk) begin
    if (center_valid) n_centres++;
    if (frame_done)   n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string when);
    check({when, ".clken"},  32'(buf_clken), 0);
    check({when, ".shift"},  32'(buf_shiftin), 0);
    check({when, ".clr"},    32'(buf_ram_clr), 0);
    check({when, ".cvalid"}, 32'(center_valid), 0);
    check({when, ".cx"},     32'(center_x), 0);
    check({when, ".cy"},     32'(center_y), 0);
    check({when, ".border"}, 32'(center_border), 0);
    check({when, ".cpix"},   32'(center_pixel), 0);
    check({when, ".done"},   32'(frame_done), 0);
  endtask

  // One clock: drive inputs, check buffer controls, then check the registered
  // centre outputs produced by this edge (ck = expected centre index, -1 none).
  task automatic step(input bit fs, input bit pv, input logic [BW-1:0] px,
                      input bit e_clken, input logic [BW-1:0] e_shift, input bit e_clr,
                      input int ck, input bit e_done);
    int ex, ey;
    bit eb;
    logic [BW-1:0] ep;
    @(negedge clk);
    frame_start = fs;
    pixel_valid = pv;
    pixel_in    = px;
    #1;
    check("clken", 32'(buf_clken), 32'(e_clken));
    if (e_clken) check("shiftin", 32'(buf_shiftin), 32'(e_shift));
    check("ram_clr", 32'(buf_ram_clr), 32'(e_clr));
    @(posedge clk);
    #1;
    check("cvalid", 32'(center_valid), 32'(ck >= 0));
    if (ck >= 0) begin
      ex = ck % LW;
      ey = ck / LW;
      eb = (ex < 2) || (ex >= LW - 2) || (ey < 2) || (ey >= FH - 2);
      ep = pix[ck];
`ifdef WINDOW5_BORDER_ZERO_EN
      if (eb) ep = '0;
`endif
      check("cx", 32'(center_x), 32'(ex));
      check("cy", 32'(center_y), 32'(ey));
      check("cborder", 32'(center_border), 32'(eb));
      check("cpixel", 32'(center_pixel), 32'(ep));
    end
    check("fdone", 32'(frame_done), 32'(e_done));
  endtask

  // gap_mode: 0 always valid, 1 alternate 1/0, 2 random gaps.
  // abort_at >= 0 raises frame_start together with that pixel.
  task automatic run_frame(input int abort_at, input int gap_mode, input bit started,
                           input bit idx_vals);
    int  n, k;
    bit  pv, tog, fs;
    for (int i = 0; i < N; i++) pix[i] = idx_vals ? BW'(i) : BW'($urandom());
    if (!started) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, -1, 1'b0);
    step(1'b0, 1'($urandom_range(0, 1)), BW'($urandom()), 1'b0, '0, 1'b1, -1, 1'b0);
    n = 0;
    k = 0;
    tog = 1'b1;
    while (k < N) begin
      case (gap_mode)
        0:       pv = 1'b1;
        1:       begin pv = tog; tog = !tog; end
        default: pv = ($urandom_range(0, 3) != 0);
      endcase
      if (pv) begin
        fs = (k == abort_at);
        step(fs, 1'b1, pix[k], 1'b1, pix[k], 1'b0, (!fs && n >= D) ? n - D : -1, 1'b0);
        if (fs) return;
        n++;
        k++;
      end else begin
        step(1'b0, 1'b0, BW'($urandom()), 1'b0, '0, 1'b0, -1, 1'b0);
      end
    end
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), BW'($urandom()), 1'b1, '0, 1'b0, n - D, i == D - 1);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    @(negedge clk);
    reset = 1'b0;
    // pixel_valid while idle must not shift
    repeat (3) step(1'b0, 1'b1, BW'($urandom()), 1'b0, '0, 1'b0, -1, 1'b0);

    run_frame(-1, 0, 1'b0, 1'b1);   // index-valued pixels, no gaps
    run_frame(-1, 1, 1'b0, 1'b0);   // alternating pixel_valid
    run_frame(25, 2, 1'b0, 1'b0);   // abort at pixel 25
    run_frame(-1, 2, 1'b1, 1'b0);   // frame restarted by the abort

    // Reset in the middle of RUN after some centres have been emitted.
    for (int i = 0; i < N; i++) pix[i] = BW'(i + 100);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, -1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, -1, 1'b0);
    for (int k = 0; k < 25; k++)
      step(1'b0, 1'b1, pix[k], 1'b1, pix[k], 1'b0, (k >= D) ? k - D : -1, 1'b0);
    @(negedge clk);
    reset       = 1'b1;
    pixel_valid = 1'b1;
    pixel_in    = pix[25];
    @(posedge clk);
    #1;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step(1'b0, 1'b1, BW'($urandom()), 1'b0, '0, 1'b0, -1, 1'b0);

    @(negedge clk);
    check("centre_count", 32'(n_centres), 32'(3 * N + 2 * (25 - D)));
    check("done_count", 32'(n_done), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window5_sequencer.md
Name: window5_sequencer

Overview:
- Drives the 5-line window buffer: feeds its shift input, generates its clock-enable and async RAM clear, and tracks frame position.
- Reports the frame coordinate of the pixel currently at the window centre (grid row 2, col 2), a valid strobe and a border flag.
- Sits between the pixel source (camera/VGA stream) and the window buffer/edge-detect datapath.
- Flushes the tail of each frame so every pixel of the frame appears once as a window centre.

Parameters:
- P_BIT_WIDTH, 24, pixel width in bits.
- P_LINE_WIDTH, 640, pixels per line; equals the buffer tap spacing.
- P_FRAME_HEIGHT, 480, lines per frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse before the first pixel of a frame.
- pixel_valid  in  1  pixel_in is valid this cycle.
- pixel_in  in  P_BIT_WIDTH  raster-order pixel.
- grid_center_in  in  P_BIT_WIDTH  centre element of the buffer's window grid.
- buf_shiftin  out  P_BIT_WIDTH  to buffer shift input.
- buf_clken  out  1  to buffer clock enable.
- buf_ram_clr  out  1  to buffer async clear.
- center_valid  out  1  centre coordinate/pixel valid.
- center_x  out  $clog2(P_LINE_WIDTH)  centre column.
- center_y  out  $clog2(P_FRAME_HEIGHT)  centre row.
- center_border  out  1  centre lies within 2 pixels of any frame edge.
- center_pixel  out  P_BIT_WIDTH  centre pixel (see Optional Feature).
- frame_done  out  1  one-cycle pulse after the last centre of a frame.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- States:
  - IDLE: waits for frame_start.
  - CLEAR: one cycle; buf_ram_clr=1; input counter and centre counter reset.
  - RUN: accepts pixels.
  - FLUSH: drains the tail of the frame.
- Transitions:
  - IDLE -> CLEAR on frame_start.
  - CLEAR -> RUN.
  - RUN -> FLUSH after pixel index N-1 is accepted, where N = P_LINE_WIDTH*P_FRAME_HEIGHT.
  - FLUSH -> IDLE after D = 2*P_LINE_WIDTH+2 flush cycles; frame_done pulses that cycle.
- buf_clken and buf_shiftin are combinational:
  - RUN: buf_clken = pixel_valid, buf_shiftin = pixel_in.
  - FLUSH: buf_clken = 1, buf_shiftin = 0.
  - Otherwise: buf_clken = 0.
- Input linear index n counts accepted shifts in RUN.
- The centre of the shift with index n is pixel n-D. A centre exists only when n >= D; FLUSH continues n past N-1.
- Centre counter (x,y) starts at (0,0) on the shift with n == D and increments once per subsequent shift.
  - x wraps at P_LINE_WIDTH-1 to 0, with y+1.
  - Stops after (P_LINE_WIDTH-1, P_FRAME_HEIGHT-1).
- Centre outputs are registered on the same clk edge that updates the buffer grid, so center_* align with the grid contents in the following cycle.
  - center_valid = 1 for exactly one cycle per centre; 0 on cycles without a shift.
  - center_pixel is sampled from grid_center_in in the cycle center_valid is high.
- center_border = (x<2) | (x>=P_LINE_WIDTH-2) | (y<2) | (y>=P_FRAME_HEIGHT-2).
- frame_start in RUN or FLUSH aborts the current frame and enters CLEAR next cycle. No centre is emitted in the abort cycle, and frame_done is not pulsed.
- pixel_valid outside RUN is ignored. Gaps in pixel_valid stall all counters.
- reset mid-frame overrides everything and returns to IDLE.

Optional Feature:
- Macro: WINDOW5_BORDER_ZERO_EN.
- Defined: center_pixel is forced to 0 when center_border = 1.
- Undefined: center_pixel always passes grid_center_in through.

Decomposition:
- Package window5_pkg:
  - WIN_SIZE = 5 and WIN_RADIUS = 2.
  - State enum: IDLE, CLEAR, RUN, FLUSH.
  - Function for D given the line width.
- Sub-module frame_pos_counter:
  - Parameterised x/y raster counter with enable, clear and last flag.
  - Instantiated twice: input position and centre position.

Test Plan (P_LINE_WIDTH=8, P_FRAME_HEIGHT=6, so D=18, N=48; bench models the buffer):
1. Reset asserted mid-RUN -> next cycle all outputs 0, state IDLE; no buf_clken until frame_start.
2. frame_start, then pixels with value = index, pixel_valid always 1 -> buf_ram_clr high one cycle; first center_valid follows shift n=18, giving (0,0), center_pixel 0, border 1.
3. Same stream -> shift n=37 yields centre (3,2), center_pixel 19, border 0.
4. Stream completes 48 pixels -> FLUSH gives 18 cycles of buf_clken=1 with shiftin 0; last centre is (7,5) with center_pixel 47; frame_done pulses once; exactly 48 centres total.
5. pixel_valid toggled 1/0 alternately -> no center_valid or buf_clken on 0 cycles; coordinates identical to test 2.
6. frame_start at pixel 25 of RUN -> CLEAR cycle, no frame_done; new frame's first centre is (0,0) at its shift 18.
